// File: rtl/bank_arb_resp_demux.sv
// Round-robin arbiter that multiplexes NumIn initiators onto one memory bank and
// routes each bank response back to the initiator whose request was accepted.
module bank_arb_resp_demux #(
    parameter int NumIn         = 4,
    parameter int ReqDataWidth  = 32,
    parameter int RespDataWidth = 32,
    parameter int RespLat       = 1,
    parameter int WriteRespOn   = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumIn-1:0]                 req_i,
    input  logic [NumIn-1:0]                 wen_i,
    input  logic [NumIn*ReqDataWidth-1:0]    data_i,
    output logic [NumIn-1:0]                 gnt_o,
    output logic [NumIn-1:0]                 vld_o,
    output logic [NumIn*RespDataWidth-1:0]   rdata_o,
    output logic                             req_o,
    output logic                             wen_o,
    output logic [ReqDataWidth-1:0]          data_o,
    input  logic                             gnt_i,
    input  logic [RespDataWidth-1:0]         rdata_i
);

    localparam int   IdxW   = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam logic WrResp = (WriteRespOn != 0);

    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] winner;
    logic            found_hi;
    logic            hs;
    logic            vld_in;

    logic [RespLat-1:0] vld_q;
    logic [IdxW-1:0]    idx_q [RespLat];

    // Two descending passes: the lowest requester at or above the pointer wins,
    // otherwise the lowest requester overall (the wrapped part of the search).
    always_comb begin
        winner   = rr_q;
        found_hi = 1'b0;
        for (int i = NumIn - 1; i >= 0; i--) begin
            if (req_i[i] && (i >= int'(rr_q))) begin
                winner   = IdxW'(i);
                found_hi = 1'b1;
            end
        end
        if (!found_hi) begin
            for (int i = NumIn - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    winner = IdxW'(i);
                end
            end
        end
    end

    assign req_o = |req_i;
    assign hs    = req_o & gnt_i;

    always_comb begin
        wen_o  = 1'b0;
        data_o = '0;
        gnt_o  = '0;
        for (int i = 0; i < NumIn; i++) begin
            if (winner == IdxW'(i)) begin
                wen_o    = wen_i[i];
                data_o   = data_i[i*ReqDataWidth +: ReqDataWidth];
                gnt_o[i] = hs;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (hs) begin
            rr_d = (winner == IdxW'(NumIn - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Response tracking: {vld, idx} travels alongside the bank latency.
    assign vld_in = hs & (~wen_o | WrResp);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int s = 0; s < RespLat; s++) begin
                idx_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= vld_in;
            idx_q[0] <= winner;
            for (int s = 1; s < RespLat; s++) begin
                vld_q[s] <= vld_q[s-1];
                idx_q[s] <= idx_q[s-1];
            end
        end
    end

    always_comb begin
        vld_o = '0;
        for (int i = 0; i < NumIn; i++) begin
            vld_o[i] = vld_q[RespLat-1] && (idx_q[RespLat-1] == IdxW'(i));
        end
    end

    assign rdata_o = {NumIn{rdata_i}};

endmodule

// File: tb/tb_bank_arb_resp_demux.sv
// Directed bench for bank_arb_resp_demux: four parameterisations share clock and reset.
module tb_bank_arb_resp_demux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // A: NumIn=4, RespLat=2, write responses on
    logic [3:0]  a_req = '0, a_wen = '0, a_gnt, a_vld;
    logic [63:0] a_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    logic [63:0] a_rdo;
    logic        a_req_o, a_wen_o, a_gi = 1'b0;
    logic [15:0] a_data_o, a_rdi = '0;

    // B: NumIn=4, RespLat=1, write responses off
    logic [3:0]  b_req = '0, b_wen = '0, b_gnt, b_vld;
    logic [63:0] b_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    logic [63:0] b_rdo;
    logic        b_req_o, b_wen_o, b_gi = 1'b0;
    logic [15:0] b_data_o, b_rdi = '0;

    // C: NumIn=3, RespLat=1
    logic [2:0]  c_req = '0, c_wen = '0, c_gnt, c_vld;
    logic [47:0] c_data = {16'h2222, 16'h1111, 16'h0000};
    logic [47:0] c_rdo;
    logic        c_req_o, c_wen_o, c_gi = 1'b0;
    logic [15:0] c_data_o, c_rdi = '0;

    // D: NumIn=1, RespLat=3
    logic        d_req = 1'b0, d_wen = 1'b0, d_gnt, d_vld;
    logic [15:0] d_data = 16'hBEEF;
    logic [15:0] d_rdo;
    logic        d_req_o, d_wen_o, d_gi = 1'b0;
    logic [15:0] d_data_o, d_rdi = '0;

    bank_arb_resp_demux #(.NumIn(4), .ReqDataWidth(16), .RespDataWidth(16), .RespLat(2), .WriteRespOn(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .wen_i(a_wen), .data_i(a_data),
        .gnt_o(a_gnt), .vld_o(a_vld), .rdata_o(a_rdo), .req_o(a_req_o), .wen_o(a_wen_o),
        .data_o(a_data_o), .gnt_i(a_gi), .rdata_i(a_rdi));

    bank_arb_resp_demux #(.NumIn(4), .ReqDataWidth(16), .RespDataWidth(16), .RespLat(1), .WriteRespOn(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .wen_i(b_wen), .data_i(b_data),
        .gnt_o(b_gnt), .vld_o(b_vld), .rdata_o(b_rdo), .req_o(b_req_o), .wen_o(b_wen_o),
        .data_o(b_data_o), .gnt_i(b_gi), .rdata_i(b_rdi));

    bank_arb_resp_demux #(.NumIn(3), .ReqDataWidth(16), .RespDataWidth(16), .RespLat(1), .WriteRespOn(1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(c_req), .wen_i(c_wen), .data_i(c_data),
        .gnt_o(c_gnt), .vld_o(c_vld), .rdata_o(c_rdo), .req_o(c_req_o), .wen_o(c_wen_o),
        .data_o(c_data_o), .gnt_i(c_gi), .rdata_i(c_rdi));

    bank_arb_resp_demux #(.NumIn(1), .ReqDataWidth(16), .RespDataWidth(16), .RespLat(3), .WriteRespOn(1)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .req_i(d_req), .wen_i(d_wen), .data_i(d_data),
        .gnt_o(d_gnt), .vld_o(d_vld), .rdata_o(d_rdo), .req_o(d_req_o), .wen_o(d_wen_o),
        .data_o(d_data_o), .gnt_i(d_gi), .rdata_i(d_rdi));

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  wen;
        logic        gi;
        logic [15:0] rd;
        logic [3:0]  egnt;
        logic [3:0]  evld;
        logic        ereq;
        logic        chk;
        logic        ewen;
        logic [15:0] edata;
    } vec_t;

    vec_t tab [19];

    function automatic vec_t mk(logic [3:0] req, logic [3:0] wen, logic gi, logic [15:0] rd,
                                logic [3:0] egnt, logic [3:0] evld, logic ereq, logic chk,
                                logic ewen, logic [15:0] edata);
        vec_t v;
        v.req = req; v.wen = wen; v.gi = gi; v.rd = rd; v.egnt = egnt; v.evld = evld;
        v.ereq = ereq; v.chk = chk; v.ewen = ewen; v.edata = edata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stall with rr at 0, then release: 1 then 3
        tab[0]  = mk(4'b1010, 4'b0000, 1'b0, 16'h0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h1111);
        tab[1]  = mk(4'b1010, 4'b0000, 1'b0, 16'h0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h1111);
        tab[2]  = mk(4'b1010, 4'b0000, 1'b0, 16'h0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h1111);
        tab[3]  = mk(4'b1010, 4'b0000, 1'b1, 16'h0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h1111);
        tab[4]  = mk(4'b1010, 4'b0000, 1'b1, 16'h0, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h3333);
        // fairness rotation 0,1,2,3,0 with responses two cycles behind
        tab[5]  = mk(4'b1111, 4'b0000, 1'b1, 16'h0, 4'b0001, 4'b0010, 1'b1, 1'b1, 1'b0, 16'h0000);
        tab[6]  = mk(4'b1111, 4'b0000, 1'b1, 16'h0, 4'b0010, 4'b1000, 1'b1, 1'b1, 1'b0, 16'h1111);
        tab[7]  = mk(4'b1111, 4'b0000, 1'b1, 16'h0, 4'b0100, 4'b0001, 1'b1, 1'b1, 1'b0, 16'h2222);
        tab[8]  = mk(4'b1111, 4'b0000, 1'b1, 16'h0, 4'b1000, 4'b0010, 1'b1, 1'b1, 1'b0, 16'h3333);
        tab[9]  = mk(4'b1111, 4'b0000, 1'b1, 16'h0, 4'b0001, 4'b0100, 1'b1, 1'b1, 1'b0, 16'h0000);
        // initiator 2 read, response A5A5 two cycles later
        tab[10] = mk(4'b0100, 4'b0000, 1'b1, 16'h0, 4'b0100, 4'b1000, 1'b1, 1'b1, 1'b0, 16'h2222);
        tab[11] = mk(4'b0000, 4'b0000, 1'b1, 16'h0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 16'h0000);
        tab[12] = mk(4'b0000, 4'b0000, 1'b1, 16'hA5A5, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0, 16'h0000);
        // write from initiator 1 still responds when write responses are on
        tab[13] = mk(4'b0010, 4'b0010, 1'b1, 16'h0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 16'h1111);
        tab[14] = mk(4'b0000, 4'b0000, 1'b0, 16'h0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        tab[15] = mk(4'b0000, 4'b0000, 1'b0, 16'h0, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 16'h0000);
        // ungranted winner 3 displaced by higher-priority newcomer 2
        tab[16] = mk(4'b1000, 4'b0000, 1'b0, 16'h0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h3333);
        tab[17] = mk(4'b1100, 4'b0000, 1'b0, 16'h0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h2222);
        tab[18] = mk(4'b1100, 4'b0000, 1'b1, 16'h0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 16'h2222);

        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        chk("reset_vld_a", 32'(a_vld), 32'h0);
        chk("reset_rr_a", 32'(u_a.rr_q), 32'h0);
        rst_n = 1'b1;
        next_cycle();

        // table on A
        for (int r = 0; r < 19; r++) begin
            a_req = tab[r].req;
            a_wen = tab[r].wen;
            a_gi  = tab[r].gi;
            a_rdi = tab[r].rd;
            @(negedge clk);
            chk($sformatf("row%0d_gnt", r), 32'(a_gnt), 32'(tab[r].egnt));
            chk($sformatf("row%0d_vld", r), 32'(a_vld), 32'(tab[r].evld));
            chk($sformatf("row%0d_req_o", r), 32'(a_req_o), 32'(tab[r].ereq));
            chk($sformatf("row%0d_rdata2", r), 32'(a_rdo[32 +: 16]), 32'(tab[r].rd));
            if (tab[r].chk) begin
                chk($sformatf("row%0d_data_o", r), 32'(a_data_o), 32'(tab[r].edata));
                chk($sformatf("row%0d_wen_o", r), 32'(a_wen_o), 32'(tab[r].ewen));
            end
            next_cycle();
        end
        a_req = '0; a_wen = '0; a_gi = 1'b0; a_rdi = '0;

        // B: write suppressed, read still responds
        b_req = 4'b0010; b_wen = 4'b0010; b_gi = 1'b1;
        @(negedge clk);
        chk("b_wr_gnt", 32'(b_gnt), 32'h2);
        chk("b_wr_vld0", 32'(b_vld), 32'h0);
        next_cycle();
        b_req = '0; b_wen = '0;
        @(negedge clk);
        chk("b_wr_vld1", 32'(b_vld), 32'h0);
        next_cycle();
        b_req = 4'b0010;
        @(negedge clk);
        chk("b_rd_gnt", 32'(b_gnt), 32'h2);
        next_cycle();
        b_req = '0; b_gi = 1'b0;
        @(negedge clk);
        chk("b_rd_vld", 32'(b_vld), 32'h2);
        next_cycle();

        // C: NumIn=3 pointer wrap from 2 to 0
        c_req = 3'b010; c_gi = 1'b1;
        @(negedge clk);
        chk("c_g1", 32'(c_gnt), 32'h2);
        next_cycle();
        chk("c_rr2", 32'(u_c.rr_q), 32'h2);
        c_req = 3'b101;
        @(negedge clk);
        chk("c_g2", 32'(c_gnt), 32'h4);
        chk("c_data2", 32'(c_data_o), 32'h2222);
        next_cycle();
        chk("c_rr_wrap", 32'(u_c.rr_q), 32'h0);
        @(negedge clk);
        chk("c_g0", 32'(c_gnt), 32'h1);
        chk("c_vld2", 32'(c_vld), 32'h4);
        next_cycle();
        c_req = '0; c_gi = 1'b0;
        @(negedge clk);
        chk("c_vld0", 32'(c_vld), 32'h1);
        next_cycle();

        // D: single initiator passthrough with three-cycle response
        d_req = 1'b1; d_gi = 1'b0;
        @(negedge clk);
        chk("d_stall_gnt", 32'(d_gnt), 32'h0);
        chk("d_req_o", 32'(d_req_o), 32'h1);
        chk("d_data_o", 32'(d_data_o), 32'hBEEF);
        next_cycle();
        d_gi = 1'b1;
        @(negedge clk);
        chk("d_gnt", 32'(d_gnt), 32'h1);
        next_cycle();
        d_req = 1'b0; d_gi = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("d_vld_t%0d", k), 32'(d_vld), (k == 3) ? 32'h1 : 32'h0);
            next_cycle();
        end
        chk("d_rr", 32'(u_d.rr_q), 32'h0);

        // reset mid-stream on A with responses in flight and rr nonzero
        a_req = 4'b1111; a_gi = 1'b1;
        @(negedge clk);
        chk("pre_rst_g3", 32'(a_gnt), 32'h8);
        next_cycle();
        @(negedge clk);
        chk("pre_rst_g0", 32'(a_gnt), 32'h1);
        next_cycle();
        a_req = '0; a_gi = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_vld", 32'(a_vld), 32'h0);
        chk("rst_rr", 32'(u_a.rr_q), 32'h0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_vld%0d", k), 32'(a_vld), 32'h0);
            next_cycle();
        end
        a_req = 4'b0110; a_gi = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", 32'(a_gnt), 32'h2);
        next_cycle();
        a_req = '0; a_gi = 1'b0;
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
